// File: rtl/flag_pkg.sv
// Shared types and helpers for the flag-sequence game controller:
// lane state encoding, move decode values and index-width helper.
package flag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOCKOUT = 2'd2
    } lane_state_t;

    // Move decode on the concatenation {secure, risk}
    localparam logic [1:0] MV_IDLE    = 2'b00;
    localparam logic [1:0] MV_RISK    = 2'b01;
    localparam logic [1:0] MV_SECURE  = 2'b10;
    localparam logic [1:0] MV_ILLEGAL = 2'b11;

    // Width needed to hold values 0..n-1, never less than one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flag_lane.sv
// One player lane: pattern-tracking FSM with idle timeout, timed lockout
// and a saturating win counter. All outputs come straight from registers.
module flag_lane
    import flag_pkg::*;
#(
    parameter int                 SEQ_LEN        = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN        = 4'b0101,
    parameter int                 TIMEOUT_CYCLES = 8,
    parameter int                 LOCKOUT_CYCLES = 4,
    parameter int                 SCORE_W        = 4,
    parameter int                 IDX_W          = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               secure,
    input  logic               risk,
    input  logic               clear_scores,
    output logic               win,
    output logic               loss,
    output logic [IDX_W-1:0]   progress,
    output logic [SCORE_W-1:0] score
);

    localparam int TO_W = idx_w(TIMEOUT_CYCLES + 1);
    localparam int LO_W = idx_w(LOCKOUT_CYCLES);

    lane_state_t        state_reg, state_next;
    logic [IDX_W-1:0]   step_reg, step_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic [LO_W-1:0]    lo_cnt_reg, lo_cnt_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               win_reg, win_next;

    logic [1:0] move;
    logic       expected;
    logic       correct;
    logic       wrong;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            step_reg   <= '0;
            to_cnt_reg <= '0;
            lo_cnt_reg <= '0;
            score_reg  <= '0;
            win_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            to_cnt_reg <= to_cnt_next;
            lo_cnt_reg <= lo_cnt_next;
            score_reg  <= score_next;
            win_reg    <= win_next;
        end
    end

    always_comb begin
        move     = {secure, risk};
        expected = PATTERN[step_reg];
        correct  = ((move == MV_SECURE) && expected) || ((move == MV_RISK) && !expected);
        wrong    = (move == MV_ILLEGAL) || ((move != MV_IDLE) && !correct);

        state_next  = state_reg;
        step_next   = step_reg;
        to_cnt_next = to_cnt_reg;
        lo_cnt_next = lo_cnt_reg;
        win_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                to_cnt_next = '0;
                lo_cnt_next = '0;
                if (correct) begin
                    state_next = ST_ARMED;
                    step_next  = IDX_W'(1);
                end else if (wrong) begin
                    state_next = ST_LOCKOUT;
                end
            end
            ST_ARMED: begin
                if (correct) begin
                    to_cnt_next = '0;
                    if (step_reg == IDX_W'(SEQ_LEN - 1)) begin
                        win_next   = 1'b1;
                        state_next = ST_IDLE;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + 1'b1;
                    end
                end else if (wrong) begin
                    state_next  = ST_LOCKOUT;
                    step_next   = '0;
                    to_cnt_next = '0;
                    lo_cnt_next = '0;
                end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next  = ST_LOCKOUT;
                    step_next   = '0;
                    to_cnt_next = '0;
                    lo_cnt_next = '0;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                // Counter parks at its last value; exit waits for both buttons released
                if (lo_cnt_reg != LO_W'(LOCKOUT_CYCLES - 1)) begin
                    lo_cnt_next = lo_cnt_reg + 1'b1;
                end else if (move == MV_IDLE) begin
                    state_next  = ST_IDLE;
                    lo_cnt_next = '0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                step_next   = '0;
                to_cnt_next = '0;
                lo_cnt_next = '0;
            end
        endcase

        if (clear_scores) begin
            score_next = '0;
        end else if (win_next && (score_reg != {SCORE_W{1'b1}})) begin
            score_next = score_reg + 1'b1;
        end else begin
            score_next = score_reg;
        end
    end

    assign win      = win_reg;
    assign loss     = (state_reg == ST_LOCKOUT);
    assign progress = step_reg;
    assign score    = score_reg;

endmodule

// File: rtl/flag_seq_arbiter.sv
// Multi-lane flag-sequence game controller: independent lanes sharing only
// the score clear, with packed per-lane outputs and a combined win flag.
module flag_seq_arbiter
    import flag_pkg::*;
#(
    parameter int                 NUM_LANES      = 2,
    parameter int                 SEQ_LEN        = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN        = 4'b0101,
    parameter int                 TIMEOUT_CYCLES = 8,
    parameter int                 LOCKOUT_CYCLES = 4,
    parameter int                 SCORE_W        = 4,
    localparam int                IDX_W          = idx_w(SEQ_LEN)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_LANES-1:0]         secure,
    input  logic [NUM_LANES-1:0]         risk,
    input  logic                         clear_scores,
    output logic [NUM_LANES-1:0]         win,
    output logic [NUM_LANES-1:0]         loss,
    output logic [NUM_LANES*IDX_W-1:0]   progress,
    output logic [NUM_LANES*SCORE_W-1:0] score,
    output logic                         any_win
);

    if (SEQ_LEN < 2) begin : g_bad_seq_len
        $error("flag_seq_arbiter: SEQ_LEN must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("flag_seq_arbiter: TIMEOUT_CYCLES must be at least 1");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
        $error("flag_seq_arbiter: LOCKOUT_CYCLES must be at least 1");
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        flag_lane #(
            .SEQ_LEN       (SEQ_LEN),
            .PATTERN       (PATTERN),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
            .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
            .SCORE_W       (SCORE_W),
            .IDX_W         (IDX_W)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .secure      (secure[gi]),
            .risk        (risk[gi]),
            .clear_scores(clear_scores),
            .win         (win[gi]),
            .loss        (loss[gi]),
            .progress    (progress[gi*IDX_W +: IDX_W]),
            .score       (score[gi*SCORE_W +: SCORE_W])
        );
    end

    // OR of registered bits only, so any_win stays aligned with win
    assign any_win = |win;

endmodule

// File: doc/flag_seq_arbiter.md
# flag_seq_arbiter

Multi-lane, parametrised flag-sequence game controller. Each lane tracks a player's secure/risk moves against a programmable pattern of configurable length. The block pulses a win on pattern completion and enters a timed lockout (loss) on a wrong move or an idle timeout. It keeps a saturating per-lane win score and sits between the debounced button front-end and the LED/score display logic.

## Interface
Parameters:
- NUM_LANES, 2: independent lanes (players).
- SEQ_LEN, 4: moves per pattern; must be ≥2.
- PATTERN, 4'b0101: SEQ_LEN bits; bit k = expected move at step k (1 = secure, 0 = risk).
- TIMEOUT_CYCLES, 8: idle cycles allowed mid-sequence before loss; must be ≥1.
- LOCKOUT_CYCLES, 4: minimum cycles spent in lockout; must be ≥1.
- SCORE_W, 4: width of each lane's win counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- secure  in  NUM_LANES  per-lane secure move request.
- risk  in  NUM_LANES  per-lane risk move request.
- clear_scores  in  1  synchronous clear of all win counters.
- win  out  NUM_LANES  one-cycle pulse per completed pattern.
- loss  out  NUM_LANES  level, high while the lane is in LOCKOUT.
- progress  out  NUM_LANES*IDX_W  per-lane step index, lane i at [i*IDX_W +: IDX_W], where IDX_W = max(1, $clog2(SEQ_LEN)).
- score  out  NUM_LANES*SCORE_W  per-lane saturating win count, lane i at [i*SCORE_W +: SCORE_W].
- any_win  out  1  OR of win.

## Operation
Move classification, per lane, per cycle:
- Exactly one of secure/risk high: valid move (secure = 1, risk = 0).
- Both high: illegal, treated as a wrong move.
- Neither high: idle.

Lane states:
- IDLE (step = 0):
  - Correct move (matches PATTERN[0]): go to ARMED, step = 1.
  - Wrong or illegal move: go to LOCKOUT.
  - Idle: stay. No timeout applies in IDLE.
- ARMED (step k, 1..SEQ_LEN-1):
  - Correct move with k < SEQ_LEN-1: step = k+1.
  - Correct move with k = SEQ_LEN-1: win pulse, score+1, return to IDLE with step = 0.
  - Wrong or illegal move: go to LOCKOUT.
  - Idle: the timeout counter increments; when it reaches TIMEOUT_CYCLES, go to LOCKOUT.
  - Any valid move clears the timeout counter.
- LOCKOUT:
  - step = 0; all inputs are ignored for moves.
  - The lockout counter counts LOCKOUT_CYCLES cycles.
  - After the count expires, exit to IDLE on the first cycle with both secure and risk low. While either input is held high, stay in LOCKOUT.

Score:
- Saturates at 2^SCORE_W-1; a win at saturation still pulses win.
- clear_scores zeroes all counters. If clear_scores and a win land in the same cycle, clear takes priority: score = 0 and win still pulses.

Lanes are fully independent and share only clear_scores.

## Timing
- Reset values: all lanes in IDLE; step, timeout and lockout counters, score, win, loss, any_win and progress all 0.
- All outputs are registered (no combinational input-to-output paths), with 1-cycle latency.
- A move sampled at edge N updates progress, win, score and loss after edge N.
- The win pulse is high for exactly one cycle. any_win aligns with win.
- loss rises after the edge that samples the wrong move, or after the edge on which the timeout counter reaches TIMEOUT_CYCLES.
- loss stays high for at least LOCKOUT_CYCLES cycles.
- A correct final move in the same cycle as clear_scores follows the clear-priority rule above.
- Reset asserted mid-sequence or mid-lockout immediately forces every lane to the reset values above. Scores are not retained across reset.

## Structure
- Shared package flag_pkg holds:
  - the lane state enum (IDLE, ARMED, LOCKOUT);
  - the move-decode localparams;
  - the IDX_W helper function.
- One sub-module, flag_lane: it holds the per-lane FSM, timeout counter, lockout counter and score counter.
- The top level generates NUM_LANES instances of flag_lane, packs the outputs, and ORs the win bits into any_win.
- Elaboration-time checks reject SEQ_LEN<2, TIMEOUT_CYCLES<1 and LOCKOUT_CYCLES<1.

## Test plan
All scenarios use NUM_LANES=2, SEQ_LEN=4, PATTERN=4'b0101, TIMEOUT=3, LOCKOUT=2, SCORE_W=2.
1. Reset: during and after reset, win = 0, loss = 0, progress = 0, score = 0.
2. Full pattern on lane 0: secure, risk, secure, risk on consecutive cycles.
   - progress reads 1, 2, 3, 0.
   - win[0] is high for exactly 1 cycle, score[0] = 1.
   - Lane 1 is unaffected.
3. Wrong move: on lane 1, secure then secure.
   - loss[1] rises after the second edge.
   - With inputs low, loss[1] stays high exactly 2 cycles, then lane 1 returns to IDLE.
   - Repeat with risk held high: loss[1] stays high until risk drops.
4. Timeout: on lane 0, secure, then 3 idle cycles.
   - loss[0] rises after the third idle edge.
   - A move on the second idle cycle instead clears the timeout and the sequence continues.
5. Illegal move and saturation:
   - secure and risk high together in IDLE → LOCKOUT.
   - Four wins on lane 0 → score[0] = 3, holding at 3 on a fifth win while win still pulses.
6. Clear priority: clear_scores on the cycle of a completing move → score[0] = 0 and win[0] pulses. Then assert reset_n low mid-sequence (progress = 2) → progress = 0 immediately.
